vram_tile_writer: RTL and testbench

//  Write side of the tile VRAM: turns (piece, attribute) cell or rectangle write requests into 8-bit tile codes.

---
 rtl/vram_tile_pkg.sv | 34 +++
 rtl/tile_code_encode.sv | 37 +++
 rtl/vram_tile_writer.sv | 180 ++++++++++++++++++
 tb/tb_vram_tile_writer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/vram_tile_pkg.sv
// Shared constants for the tile VRAM writer: piece/attribute encodings, tile codes and FSM states.
package vram_tile_pkg;

  localparam logic [2:0] PIECE_I = 3'd0;
  localparam logic [2:0] PIECE_T = 3'd1;
  localparam logic [2:0] PIECE_O = 3'd2;
  localparam logic [2:0] PIECE_J = 3'd3;
  localparam logic [2:0] PIECE_L = 3'd4;
  localparam logic [2:0] PIECE_S = 3'd5;
  localparam logic [2:0] PIECE_Z = 3'd6;

  localparam logic [2:0] ATTR_NORMAL    = 3'd0;
  localparam logic [2:0] ATTR_LIGHT     = 3'd1;
  localparam logic [2:0] ATTR_LIGHT_ALT = 3'd2;
  localparam logic [2:0] ATTR_SHADOW    = 3'd3;
  localparam logic [2:0] ATTR_GARBAGE   = 3'd4;
  localparam logic [2:0] ATTR_BG        = 3'd5;
  localparam logic [2:0] ATTR_BG_DARK   = 3'd6;

  localparam logic [7:0] CODE_SHADOW    = 8'd7;
  localparam logic [7:0] CODE_GARBAGE   = 8'd8;
  localparam logic [7:0] CODE_BG        = 8'd9;
  localparam logic [7:0] CODE_BG_DARK   = 8'd10;
  localparam logic [7:0] LIGHT_BASE     = 8'd11;
  localparam logic [7:0] LIGHT_ALT_BASE = 8'd18;
  localparam logic [7:0] CODE_ERR       = 8'h3F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wr_state_e;

endpackage

// File: rtl/tile_code_encode.sv
// Combinational (piece, attribute) -> 8-bit tile code; the inverse of the video-side tile decoder.
module tile_code_encode
  import vram_tile_pkg::*;
(
  input  logic [2:0] i_piece,
  input  logic [2:0] i_attr,
  output logic [7:0] o_code
);

  logic w_piece_ok;
  assign w_piece_ok = (i_piece <= PIECE_Z);

  // Piece-coloured attributes need a valid piece; anything undefined maps to the magenta error tile.
  always_comb begin
    o_code = CODE_ERR;
    case (i_attr)
      ATTR_NORMAL: begin
        if (w_piece_ok) o_code = {5'd0, i_piece};
        else            o_code = CODE_ERR;
      end
      ATTR_LIGHT: begin
        if (w_piece_ok) o_code = LIGHT_BASE + {5'd0, i_piece};
        else            o_code = CODE_ERR;
      end
      ATTR_LIGHT_ALT: begin
        if (w_piece_ok) o_code = LIGHT_ALT_BASE + {5'd0, i_piece};
        else            o_code = CODE_ERR;
      end
      ATTR_SHADOW:  o_code = CODE_SHADOW;
      ATTR_GARBAGE: o_code = CODE_GARBAGE;
      ATTR_BG:      o_code = CODE_BG;
      ATTR_BG_DARK: o_code = CODE_BG_DARK;
      default:      o_code = CODE_ERR;
    endcase
  end

endmodule

// File: rtl/vram_tile_writer.sv
// Tile VRAM write sequencer: one VRAM write per cell of a (piece, attr) rectangle, x inner / y outer.
// Define TILE_WRITER_CLEAR_EN to add the clear_req port (whole-field fill with the BG code).
module vram_tile_writer
  import vram_tile_pkg::*;
#(
  parameter int COLS      = 10,
  parameter int ROWS      = 20,
  parameter int COL_W     = 4,
  parameter int ROW_W     = 5,
  parameter int ADDR_W    = 9,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [COL_W-1:0]  req_x,
  input  logic [ROW_W-1:0]  req_y,
  input  logic [COL_W-1:0]  req_w,
  input  logic [ROW_W-1:0]  req_h,
  input  logic [2:0]        req_piece,
  input  logic [2:0]        req_attr,
`ifdef TILE_WRITER_CLEAR_EN
  input  logic              clear_req,
`endif
  output logic              vram_we,
  input  logic              vram_gnt,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_wdata,
  output logic              busy,
  output logic              done
);

  // One extra bit so rectangles running past the field edge can be walked and clipped.
  localparam int XW = COL_W + 1;
  localparam int YW = ROW_W + 1;

  wr_state_e         r_state;
  wr_state_e         w_next_state;
  logic [XW-1:0]     r_x, r_x0, r_xlast;
  logic [YW-1:0]     r_y, r_ylast;
  logic [ADDR_W-1:0] r_row_base, r_addr;
  logic              r_we;
  logic [7:0]        r_wdata;

  logic [7:0]        w_code, w_ld_code;
  logic              w_clear, w_ready, w_start, w_ld_empty;
  logic [XW-1:0]     w_ld_x, w_ld_xlast, w_nx;
  logic [YW-1:0]     w_ld_y, w_ld_ylast, w_ny;
  logic [ADDR_W-1:0] w_ld_base, w_nbase;
  logic              w_last_col, w_last_row, w_last_cell, w_cell_done;

  function automatic logic f_in_field(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return (x < XW'(COLS)) && (y < YW'(ROWS));
  endfunction

  tile_code_encode u_encode (
    .i_piece (req_piece),
    .i_attr  (req_attr),
    .o_code  (w_code)
  );

`ifdef TILE_WRITER_CLEAR_EN
  assign w_clear = (r_state == ST_IDLE) && clear_req;
`else
  assign w_clear = 1'b0;
`endif
  assign w_ready = (r_state == ST_IDLE) && !w_clear;
  assign w_start = (req_valid && w_ready) || w_clear;

  // Rectangle parameters captured at acceptance; a clear is a full-field BG rectangle.
  always_comb begin
    w_ld_x     = {1'b0, req_x};
    w_ld_y     = {1'b0, req_y};
    w_ld_xlast = {1'b0, req_x} + {1'b0, req_w} - XW'(1);
    w_ld_ylast = {1'b0, req_y} + {1'b0, req_h} - YW'(1);
    w_ld_code  = w_code;
    w_ld_empty = (req_w == '0) || (req_h == '0);
    if (w_clear) begin
      w_ld_x     = '0;
      w_ld_y     = '0;
      w_ld_xlast = XW'(COLS - 1);
      w_ld_ylast = YW'(ROWS - 1);
      w_ld_code  = CODE_BG;
      w_ld_empty = 1'b0;
    end else begin
      w_ld_code  = w_code;
    end
  end

  // Constant-coefficient product, used once per request; per-row stepping is add-only.
  assign w_ld_base = ADDR_W'(BASE_ADDR) + ADDR_W'(w_ld_y) * ADDR_W'(COLS);

  assign w_last_col  = (r_x == r_xlast);
  assign w_last_row  = (r_y == r_ylast);
  assign w_last_cell = w_last_col && w_last_row;
  assign w_cell_done = (r_state == ST_WRITE) && (!r_we || vram_gnt);

  // Next cell position and row base after the current cell completes.
  always_comb begin
    w_nx    = r_x + XW'(1);
    w_ny    = r_y;
    w_nbase = r_row_base;
    if (w_last_col) begin
      w_nx    = r_x0;
      w_ny    = r_y + YW'(1);
      w_nbase = r_row_base + ADDR_W'(COLS);
    end else begin
      w_nx    = r_x + XW'(1);
      w_ny    = r_y;
      w_nbase = r_row_base;
    end
  end

  // FSM next state.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_next_state = w_ld_empty ? ST_DONE : ST_WRITE;
        else         w_next_state = ST_IDLE;
      end
      ST_WRITE: begin
        if (w_cell_done && w_last_cell) w_next_state = ST_DONE;
        else                            w_next_state = ST_WRITE;
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Cell walker and registered VRAM write port; outputs hold while a write is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x        <= '0;
      r_x0       <= '0;
      r_xlast    <= '0;
      r_y        <= '0;
      r_ylast    <= '0;
      r_row_base <= '0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= 8'd0;
    end else if (w_start) begin
      r_x        <= w_ld_x;
      r_x0       <= w_ld_x;
      r_xlast    <= w_ld_xlast;
      r_y        <= w_ld_y;
      r_ylast    <= w_ld_ylast;
      r_row_base <= w_ld_base;
      r_addr     <= w_ld_base + ADDR_W'(w_ld_x);
      r_wdata    <= w_ld_code;
      r_we       <= !w_ld_empty && f_in_field(w_ld_x, w_ld_y);
    end else if (w_cell_done) begin
      if (w_last_cell) begin
        r_we <= 1'b0;
      end else begin
        r_x        <= w_nx;
        r_y        <= w_ny;
        r_row_base <= w_nbase;
        r_addr     <= w_nbase + ADDR_W'(w_nx);
        r_we       <= f_in_field(w_nx, w_ny);
      end
    end
  end

  assign req_ready  = w_ready;
  assign vram_we    = r_we;
  assign vram_addr  = r_addr;
  assign vram_wdata = r_wdata;
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_vram_tile_writer.sv
// Self-checking bench for vram_tile_writer: directed cases plus random rectangles against a cell-list model.
module tb_vram_tile_writer;

  localparam int COLS      = 10;
  localparam int ROWS      = 20;
  localparam int COL_W     = 4;
  localparam int ROW_W     = 5;
  localparam int ADDR_W    = 9;
  localparam int BASE_ADDR = 0;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [COL_W-1:0]  req_x, req_w;
  logic [ROW_W-1:0]  req_y, req_h;
  logic [2:0]        req_piece, req_attr;
`ifdef TILE_WRITER_CLEAR_EN
  logic              clear_req;
`endif
  logic              vram_we, vram_gnt;
  logic [ADDR_W-1:0] vram_addr;
  logic [7:0]        vram_wdata;
  logic              busy, done;

  int n_vec = 0;
  int n_err = 0;

  vram_tile_writer #(
    .COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W),
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_w      (req_w),
    .req_h      (req_h),
    .req_piece  (req_piece),
    .req_attr   (req_attr),
`ifdef TILE_WRITER_CLEAR_EN
    .clear_req  (clear_req),
`endif
    .vram_we    (vram_we),
    .vram_gnt   (vram_gnt),
    .vram_addr  (vram_addr),
    .vram_wdata (vram_wdata),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference tile code derived from the attribute table.
  function automatic int ref_code(input int piece, input int attr);
    if (attr == 7) return 'h3F;
    if (attr >= 3) return attr + 4;
    if (piece == 7) return 'h3F;
    if (attr == 0) return piece;
    if (attr == 1) return 11 + piece;
    return 18 + piece;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, drive the grant (first hold_n write cycles refused, then gnt_pct % random),
  // and compare the completed writes and timing with the model.
  task automatic run_req(input int x, input int y, input int w, input int h,
                         input int piece, input int attr, input int gnt_pct,
                         input int hold_n, input string tag);
    int exp_addr[$], exp_data[$], got_addr[$], got_data[$];
    int cycles, stalls, budget, hold_left;
    bit held, finished;
    logic [31:0] held_val;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        if ((x + c) < COLS && (y + r) < ROWS) begin
          exp_addr.push_back((BASE_ADDR + (y + r) * COLS + x + c) % (1 << ADDR_W));
          exp_data.push_back(ref_code(piece, attr));
        end
    chk({tag, " ready_idle"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_x = COL_W'(x); req_y = ROW_W'(y); req_w = COL_W'(w); req_h = ROW_W'(h);
    req_piece = 3'(piece); req_attr = 3'(attr);
    tick();
    req_valid = 1'b0;
    req_x = COL_W'($urandom); req_y = ROW_W'($urandom);
    req_w = COL_W'($urandom); req_h = ROW_W'($urandom);
    req_piece = 3'($urandom); req_attr = 3'($urandom);
    cycles = 0; stalls = 0; held = 1'b0; finished = 1'b0; hold_left = hold_n;
    held_val = '0;
    budget = 8 * w * h + 50;
    while (!finished && cycles < budget) begin
      if (done) begin
        finished = 1'b1;
      end else begin
        if (cycles == 0) chk({tag, " busy"}, {30'd0, busy, req_ready}, 32'd2);
        if (held) chk({tag, " held"}, {22'd0, vram_we, vram_addr}, held_val);
        if (held) chk({tag, " held_data"}, {24'd0, vram_wdata}, {24'd0, 8'(exp_data[0])});
        if (vram_we && hold_left > 0) begin
          vram_gnt = 1'b0;
          hold_left--;
        end else begin
          vram_gnt = ($urandom_range(99) < gnt_pct);
        end
        if (vram_we && vram_gnt) begin
          got_addr.push_back(int'(vram_addr));
          got_data.push_back(int'(vram_wdata));
        end
        held = vram_we && !vram_gnt;
        if (held) begin
          stalls++;
          held_val = {22'd0, vram_we, vram_addr};
        end
        cycles++;
        tick();
      end
    end
    chk({tag, " done_seen"}, {31'd0, finished}, 32'd1);
    chk({tag, " done_cycle"}, {29'd0, req_ready, busy, vram_we}, 32'd2);
    chk({tag, " cycles"}, cycles, w * h + stalls);
    chk({tag, " nwrites"}, got_addr.size(), exp_addr.size());
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
      chk({tag, " addr"}, got_addr[i], exp_addr[i]);
      chk({tag, " data"}, got_data[i], exp_data[i]);
    end
    vram_gnt = 1'b1;
    tick();
    chk({tag, " after_done"}, {29'd0, done, req_ready, busy}, 32'd2);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; vram_gnt = 1'b0;
    req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_piece = '0; req_attr = '0;
`ifdef TILE_WRITER_CLEAR_EN
    clear_req = 1'b0;
`endif
    repeat (3) tick();
    chk("reset_outs", {13'd0, vram_we, vram_addr, vram_wdata, busy, done}, 32'd0);
    rst = 1'b0;
    tick();
    chk("reset_ready", {31'd0, req_ready}, 32'd1);
    vram_gnt = 1'b1;

    run_req(3, 2, 1, 1, 3, 0, 100, 0, "single_J");
    run_req(8, 19, 4, 2, 2, 3, 100, 0, "clip_shadow");
    run_req(4, 7, 1, 1, 6, 2, 100, 3, "stall_lalt_Z");
    run_req(5, 5, 0, 3, 1, 0, 100, 0, "empty_w");
    run_req(5, 5, 3, 0, 1, 0, 100, 0, "empty_h");
    run_req(15, 31, 15, 31, 0, 1, 100, 0, "all_clipped");
    run_req(0, 0, 10, 20, 4, 5, 100, 0, "full_field");

    for (int p = 0; p < 8; p++)
      for (int a = 0; a < 8; a++)
        run_req($urandom_range(COLS - 1), $urandom_range(ROWS - 1), 1, 1, p, a, 100, 0, "sweep");

    for (int i = 0; i < 40; i++) begin
      if (i < 30)
        run_req($urandom_range(15), $urandom_range(31), $urandom_range(6), $urandom_range(6),
                $urandom_range(7), $urandom_range(7), (i % 2 == 0) ? 100 : 70, 0, "rand_small");
      else
        run_req($urandom_range(15), $urandom_range(31), $urandom_range(15), $urandom_range(31),
                $urandom_range(7), $urandom_range(7), 75, 0, "rand_big");
    end

    // Reset in the middle of a 3x3 rectangle after four completed writes.
    vram_gnt = 1'b1;
    req_valid = 1'b1; req_x = 4'd2; req_y = 5'd3; req_w = 4'd3; req_h = 5'd3;
    req_piece = 3'd1; req_attr = 3'd0;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rst_pre_we", {31'd0, vram_we}, 32'd1);
      tick();
    end
    rst = 1'b1;
    tick();
    chk("rst_abort", {29'd0, vram_we, busy, done}, 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_recover", {30'd0, req_ready, done}, 32'd2);

`ifdef TILE_WRITER_CLEAR_EN
    begin
      int n_wr, n_cyc;
      bit bad;
      clear_req = 1'b1; req_valid = 1'b1;
      req_x = 4'd1; req_y = 5'd1; req_w = 4'd1; req_h = 5'd1; req_piece = 3'd0; req_attr = 3'd0;
      #1;
      chk("clr_ready_low", {31'd0, req_ready}, 32'd0);
      tick();
      clear_req = 1'b0;
      n_wr = 0; n_cyc = 0; bad = 1'b0;
      while (!done && n_cyc < 400) begin
        if (vram_we) begin
          if (int'(vram_addr) != n_wr || vram_wdata != 8'h09) bad = 1'b1;
          n_wr++;
        end
        n_cyc++;
        tick();
      end
      chk("clr_writes", n_wr, 200);
      chk("clr_content", {31'd0, bad}, 32'd0);
      tick();
      chk("clr_then_ready", {31'd0, req_ready}, 32'd1);
      tick();
      req_valid = 1'b0;
      chk("clr_then_req", {31'd0, vram_we}, 32'd1);
      chk("clr_then_addr", {23'd0, vram_addr}, 32'd11);
      repeat (3) tick();
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
